// File: rtl/bit_serializer.sv
// Parallel-to-serial stage: accepts WIDTH-bit words over valid/ready and
// emits one bit per clock, streaming back-to-back words without a bubble.
module bit_serializer #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1,
   parameter bit          IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic             out_bit,
   output logic             out_valid,
   output logic             busy,
   output logic             word_done
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             in_shift;
   logic             last_bit;
   logic             accept;
   logic [WIDTH-1:0] shreg_shifted;

   assign in_shift = (state_q == SHIFT);
   assign last_bit = in_shift && (cnt_q == LAST_IDX);
   assign accept   = s_valid && s_ready;

   // Shift toward whichever end feeds out_bit, zero-filling the far end.
   assign shreg_shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                    : {1'b0, shreg_q[WIDTH-1:1]};

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               shreg_d = s_data;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (!last_bit) begin
               shreg_d = shreg_shifted;
               cnt_d   = cnt_q + CW'(1);
            end else if (accept) begin
               shreg_d = s_data;
               cnt_d   = '0;
            end else begin
               shreg_d = '0;
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs are qualified by rst_n so the detector sees idle while reset is held.
   always_comb begin
      s_ready   = rst_n && ((state_q == IDLE) || last_bit);
      out_valid = rst_n && in_shift;
      busy      = rst_n && in_shift;
      word_done = rst_n && last_bit;
      out_bit   = IDLE_BIT;
      if (out_valid) begin
         out_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
      end
   end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
Parallel-to-serial stage feeding the single-bit input of the overlapping 1011 sequence detector. It accepts WIDTH-bit words over a valid/ready handshake. It shifts each word out one bit per clock, with a qualifying out_valid. Back-to-back words stream with no idle bubble, so the downstream detector sees a contiguous bitstream.

Parameters:
WIDTH, 8, word width in bits; legal range WIDTH >= 2.
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
IDLE_BIT, 0, value driven on out_bit whenever out_valid = 0.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  synchronous, active-low reset.
s_data  input  WIDTH  parallel word; sampled only on the accept edge.
s_valid  input  1  upstream word available.
s_ready  output  1  block can accept a word this cycle (combinational).
out_bit  output  1  serial data to the detector's in_bit.
out_valid  output  1  out_bit carries a word bit this cycle.
busy  output  1  state == SHIFT.
word_done  output  1  high during the cycle the last bit of a word is on out_bit.

Behaviour:
- Reset is synchronous: on a rising edge with rst_n = 0, the block enters the following state.
  - state = IDLE, shift register = 0, bit counter = 0.
  - Any word in flight is discarded; no partial completion and no word_done.
- Outputs while rst_n = 0 or in IDLE: out_valid = 0, out_bit = IDLE_BIT, busy = 0, word_done = 0.
- s_ready is forced to 0 while rst_n = 0.
- State machine has two states, IDLE and SHIFT. Counter width is clog2(WIDTH).
- Accept condition: accept = s_valid && s_ready.
- s_ready definition: s_ready = rst_n && (state == IDLE || (state == SHIFT && cnt == WIDTH-1)).
- IDLE: on an accept, the shift register loads s_data, cnt loads 0, and the next state is SHIFT. Otherwise the block stays in IDLE.
- SHIFT outputs:
  - out_valid = 1.
  - out_bit = shreg[WIDTH-1] when MSB_FIRST = 1, or shreg[0] when MSB_FIRST = 0.
  - Both are driven from registers only; there is no combinational path from s_data to out_bit.
- SHIFT with cnt < WIDTH-1: the shift register shifts toward the output end, filling with 0, and cnt increments.
- SHIFT with cnt == WIDTH-1:
  - word_done = 1.
  - On an accept, the block reloads the shift register and sets cnt = 0, staying in SHIFT. The next cycle carries bit 0 of the new word, so there is no gap.
  - Without an accept, the next state is IDLE.
- Latency: the first bit appears the cycle after the accept edge. A word occupies exactly WIDTH consecutive out_valid cycles.
- s_valid may deassert without an accept; this has no effect. s_data changes while not accepting are ignored.
- Downstream has no backpressure; the detector consumes one bit per clk. During out_valid = 0 gaps the detector sees IDLE_BIT (0 by default, which breaks any partial 1011 match).

Test Plan:
- Reset check: assert rst_n = 0 for 2 edges with s_valid = 1 -> s_ready = 0, out_valid = 0, out_bit = 0, busy = 0, and no word is accepted.
- Single word: MSB_FIRST = 1, s_data = 8'hB0 accepted at edge T.
  - out_bit = 1,0,1,1,0,0,0,0 over cycles T+1..T+8 with out_valid = 1.
  - word_done only in cycle T+8; out_valid = 0 at T+9.
- Back-to-back: s_valid held with 8'hB0 then 8'h0D.
  - s_ready is high only in IDLE and in the last-bit cycle.
  - 16 contiguous out_valid cycles carry 10110000_00001101.
  - word_done pulses at bit 8 and bit 16.
- LSB-first: MSB_FIRST = 0, s_data = 8'h0D -> out_bit = 1,0,1,1,0,0,0,0.
- Mid-word reset: apply rst_n = 0 for one edge after 3 bits of 8'hFF have been sent -> the next cycle has out_valid = 0, out_bit = IDLE_BIT, no word_done; after release, a new word serializes from its first bit.
- Integration with the 1011 detector: feed 8'hB6 = 10110110, MSB-first.
  - The detector reports exactly two detections, for the overlapping matches ending at bits 4 and 7.
  - With an idle gap inserted between 8'h05 and 8'hB0, no spurious match spans the gap.
